conv33_out_stream: RTL and testbench

// - Downstream stage of the 3x3 line-buffer conv: consumes the 9 window taps from the buffer, sums them in a
//   2-stage pipeline, queues results in a small FIFO, presents a ready/valid output stream.
// - Owns the pixel/row counters that decide which taps form a valid 3x3 window.
// - Generates the buffer advance strobe, so the buffer and output stream stay in lockstep under backpressure.

---
 rtl/conv33_pkg.sv | 17 +
 rtl/conv33_out_stream_if.sv | 24 ++
 rtl/conv33_sfifo.sv | 66 ++++++
 rtl/conv33_out_stream.sv | 129 ++++++++++++
 tb/tb_conv33_out_stream.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv33_pkg.sv
// Shared widths, tap-window type and the unsigned 20->16 bit clamp used by the
// 3x3 conv output stage.
package conv33_pkg;

  localparam int WORD_W = 16;
  localparam int ACC_W  = 20;
  localparam int TAPS   = 9;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t tap_win_t [TAPS];

  // Any set bit above the word means the sum no longer fits in 16 bits.
  function automatic word_t saturate(input logic [ACC_W-1:0] acc);
    return (|acc[ACC_W-1:WORD_W]) ? {WORD_W{1'b1}} : acc[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/conv33_out_stream_if.sv
// Pixel-in / result-out stream bundle between the line buffer, the conv output
// stage (slave) and whatever sources pixels and sinks results (master).
interface conv33_out_stream_if;
  import conv33_pkg::*;

  logic     in_valid;
  logic     in_ready;
  logic     pix_adv;
  tap_win_t taps;
  logic     out_valid;
  logic     out_ready;
  word_t    out_data;

  modport master (
    output in_valid, taps, out_ready,
    input  in_ready, pix_adv, out_valid, out_data
  );

  modport slave (
    input  in_valid, taps, out_ready,
    output in_ready, pix_adv, out_valid, out_data
  );

endinterface

// File: rtl/conv33_sfifo.sv
// Synchronous FIFO with a registered head: rd_data always holds the current head,
// and keeps the last popped value once the FIFO runs empty.
module conv33_sfifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next, wr_ptr_inc, rd_ptr_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             push, pop, bypass;

  assign push  = wr_en;
  assign pop   = rd_en && (count_reg != '0);
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;
  assign rd_data = rd_data_reg;

  always_comb begin
    wr_ptr_inc  = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    rd_ptr_inc  = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    wr_ptr_next = push ? wr_ptr_inc : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_inc : rd_ptr_reg;
    count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    // Nothing older survives this cycle, so the new head is the word being written.
    bypass      = (count_reg == CNT_W'(pop));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) begin
        rd_data_reg <= bypass ? wr_data : mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/conv33_out_stream.sv
// 3x3 conv output stage: window counters, credit-based input gating, 2-stage tap
// summer and result FIFO. Define CONV33_SAT_EN to clamp sums to 16'hFFFF instead of wrapping.
module conv33_out_stream
  import conv33_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  conv33_out_stream_if.slave strm,
  output logic               frame_done,
  output logic               busy
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;

  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             last_col, last_row, win;
  logic             in_ready_w, pix_adv_w;
  logic [OCC_W-1:0] occ;

  logic [ACC_W-1:0] p_next [3];
  logic [ACC_W-1:0] p_reg  [3];
  logic [ACC_W-1:0] s_reg;
  logic             v1_reg, v2_reg, frame_done_reg;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  word_t            fifo_din;

  // Every accepted window pixel reserves a FIFO slot until it is popped, so the
  // pipeline never has to stall; pops in this cycle only free credit next cycle.
  assign occ        = OCC_W'(fifo_count) + OCC_W'(v1_reg) + OCC_W'(v2_reg);
  assign in_ready_w = rst_n && (occ < OCC_W'(DEPTH));
  assign pix_adv_w  = strm.in_valid && in_ready_w;

  assign strm.in_ready = in_ready_w;
  assign strm.pix_adv  = pix_adv_w;

  assign last_col = (col_reg == COL_W'(IMG_W - 1));
  assign last_row = (row_reg == ROW_W'(IMG_H - 1));
  assign win      = (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (pix_adv_w) begin
      if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg        <= '0;
      row_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      frame_done_reg <= pix_adv_w && last_col && last_row;
    end
  end

  // One row of the window per partial sum: taps [3r .. 3r+2].
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign p_next[gi] = ACC_W'(strm.taps[3*gi])
                      + ACC_W'(strm.taps[3*gi+1])
                      + ACC_W'(strm.taps[3*gi+2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        p_reg[i] <= '0;
      end
      s_reg  <= '0;
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      if (pix_adv_w) begin
        for (int i = 0; i < 3; i++) begin
          p_reg[i] <= p_next[i];
        end
      end
      v1_reg <= pix_adv_w && win;
      s_reg  <= p_reg[0] + p_reg[1] + p_reg[2];
      v2_reg <= v1_reg;
    end
  end

`ifdef CONV33_SAT_EN
  assign fifo_din = saturate(s_reg);
`else
  assign fifo_din = s_reg[WORD_W-1:0];
`endif

  conv33_sfifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (v2_reg),
    .wr_data (fifo_din),
    .rd_en   (strm.out_ready),
    .rd_data (strm.out_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign strm.out_valid = !fifo_empty;
  assign frame_done     = frame_done_reg;
  assign busy           = v1_reg || v2_reg || !fifo_empty;

  // Credit accounting makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(v2_reg && fifo_full));

endmodule

// File: tb/tb_conv33_out_stream.sv
// Scoreboard bench for conv33_out_stream: a 4x4 and an 8x5 instance, expected sums
// derived from the accepted pixel's frame position and its taps.
module tb_conv33_out_stream;
  import conv33_pkg::*;

  localparam int DEP     = 4;
  localparam int M_CONST = 0;
  localparam int M_SEQ   = 1;
  localparam int M_RAND  = 2;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  int       cyc = 0;
  int       n_cmp = 0;
  int       n_bad = 0;

  logic     in_valid_d  [2];
  tap_win_t taps_d      [2];
  logic     out_ready_d [2];
  int       ready_mode  [2];

  logic     in_ready_o   [2];
  logic     pix_adv_o    [2];
  logic     out_valid_o  [2];
  word_t    out_data_o   [2];
  logic     frame_done_o [2];
  logic     busy_o       [2];

  int       n_out [2];
  int       n_fd  [2];
  int       q_len [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int u, input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", u, nm, act, exp, cyc);
    end
  endtask

  function automatic word_t ref_out(input int s);
`ifdef CONV33_SAT_EN
    if (s > 65535) return 16'hFFFF;
`endif
    return word_t'(s & 32'hFFFF);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_u
    localparam int W = (gi == 0) ? 4 : 8;
    localparam int H = (gi == 0) ? 4 : 5;

    conv33_out_stream_if ifc ();

    assign ifc.in_valid     = in_valid_d[gi];
    assign ifc.taps         = taps_d[gi];
    assign ifc.out_ready    = out_ready_d[gi];
    assign in_ready_o[gi]   = ifc.in_ready;
    assign pix_adv_o[gi]    = ifc.pix_adv;
    assign out_valid_o[gi]  = ifc.out_valid;
    assign out_data_o[gi]   = ifc.out_data;

    conv33_out_stream #(
      .IMG_W (W),
      .IMG_H (H),
      .DEPTH (DEP)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .strm       (ifc),
      .frame_done (frame_done_o[gi]),
      .busy       (busy_o[gi])
    );

    word_t exp_q [$];
    int    k = 0;
    int    outstanding = 0;
    int    last_acc_cyc = -10;
    int    first_win_cyc = -1;
    bit    first_seen = 1'b0;
    word_t last_data = '0;
    int    col_m, row_m, sum_m;

    always @(negedge clk) begin
      if (!rst_n) begin
        chk(gi, "rst_out_valid", int'(out_valid_o[gi]), 0);
        chk(gi, "rst_in_ready", int'(in_ready_o[gi]), 0);
        chk(gi, "rst_busy", int'(busy_o[gi]), 0);
        chk(gi, "rst_frame_done", int'(frame_done_o[gi]), 0);
        chk(gi, "rst_out_data", int'(out_data_o[gi]), 0);
        exp_q.delete();
        k = 0;
        outstanding = 0;
        last_acc_cyc = -10;
        first_win_cyc = -1;
        first_seen = 1'b0;
        last_data = '0;
      end else begin
        chk(gi, "in_ready", int'(in_ready_o[gi]), int'(outstanding < DEP));
        chk(gi, "pix_adv", int'(pix_adv_o[gi]), int'(in_valid_d[gi] && in_ready_o[gi]));
        chk(gi, "frame_done", int'(frame_done_o[gi]), int'(last_acc_cyc == cyc - 1));
        chk(gi, "busy", int'(busy_o[gi]), int'(outstanding > 0));
        if (frame_done_o[gi]) n_fd[gi]++;
        if (out_valid_o[gi] && !first_seen) begin
          first_seen = 1'b1;
          chk(gi, "first_latency", cyc - first_win_cyc, 3);
        end
        if (!out_valid_o[gi]) begin
          chk(gi, "empty_hold", int'(out_data_o[gi]), int'(last_data));
        end
        if (out_valid_o[gi] && out_ready_d[gi]) begin
          $display("u%0d out #%0d data=%04h", gi, n_out[gi], out_data_o[gi]);
          if (exp_q.size() == 0) begin
            chk(gi, "unexpected_output", int'(out_data_o[gi]), -1);
          end else begin
            chk(gi, "out_data", int'(out_data_o[gi]), int'(exp_q.pop_front()));
          end
          last_data = out_data_o[gi];
          n_out[gi]++;
          outstanding--;
        end
        if (in_valid_d[gi] && in_ready_o[gi]) begin
          col_m = k % W;
          row_m = k / W;
          if (row_m >= 2 && col_m >= 2) begin
            sum_m = 0;
            for (int i = 0; i < 9; i++) sum_m += int'(taps_d[gi][i]);
            exp_q.push_back(ref_out(sum_m));
            outstanding++;
            if (first_win_cyc < 0) first_win_cyc = cyc;
          end
          if (k == W * H - 1) begin
            k = 0;
            last_acc_cyc = cyc;
          end else begin
            k++;
          end
        end
      end
      q_len[gi] = exp_q.size();
    end
  end

  initial begin
    out_ready_d[0] = 1'b0;
    out_ready_d[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        if (ready_mode[u] == 2) out_ready_d[u] = 1'($urandom_range(0, 1));
        else                    out_ready_d[u] = (ready_mode[u] != 0);
      end
    end
  end

  task automatic feed(input int u, input int npix, input int mode, input word_t val);
    int g;
    for (int p = 0; p < npix; p++) begin
      for (int i = 0; i < 9; i++) begin
        if (mode == M_CONST)     taps_d[u][i] = val;
        else if (mode == M_SEQ)  taps_d[u][i] = word_t'(i + 1);
        else                     taps_d[u][i] = word_t'($urandom);
      end
      in_valid_d[u] = 1'b1;
      g = 0;
      @(negedge clk);
      while (!in_ready_o[u] && g < 2000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 2000) begin
        chk(u, "feed_timeout", g, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid_d[u] = 1'b0;
  endtask

  task automatic wait_drain(input int u);
    int g;
    g = 0;
    @(negedge clk);
    while ((q_len[u] != 0 || busy_o[u]) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk(u, "drain_within_budget", int'(g < 2000), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_out, base_fd;
    for (int u = 0; u < 2; u++) begin
      in_valid_d[u] = 1'b0;
      ready_mode[u] = 0;
      n_out[u] = 0;
      n_fd[u] = 0;
      q_len[u] = 0;
      for (int i = 0; i < 9; i++) taps_d[u][i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 4x4, all ones, full-rate sink
    ready_mode[0] = 1;
    @(posedge clk);
    #1;
    feed(0, 16, M_CONST, 16'd1);
    wait_drain(0);
    chk(0, "ones_outputs", n_out[0], 4);
    chk(0, "ones_frame_done", n_fd[0], 1);

    // 9 x 16'h2000 overflows 16 bits: wraps or clamps
    feed(0, 16, M_CONST, 16'h2000);
    wait_drain(0);
    chk(0, "big_outputs", n_out[0], 8);

    // taps 1..9 sum to 45
    feed(0, 16, M_SEQ, 16'd0);
    wait_drain(0);
    chk(0, "seq_outputs", n_out[0], 12);
    chk(0, "seq_frame_done", n_fd[0], 3);

    // 8x5, stalled sink until credit runs out, then release
    ready_mode[1] = 0;
    @(posedge clk);
    #1;
    fork
      feed(1, 40, M_RAND, 16'd0);
      begin
        repeat (60) @(negedge clk);
        chk(1, "bp_in_ready_low", int'(in_ready_o[1]), 0);
        chk(1, "bp_no_output", n_out[1], 0);
        ready_mode[1] = 1;
      end
    join
    wait_drain(1);
    chk(1, "bp_outputs", n_out[1], 18);
    chk(1, "bp_frame_done", n_fd[1], 1);

    // two results queued, then reset mid-frame
    ready_mode[1] = 0;
    @(posedge clk);
    #1;
    feed(1, 20, M_RAND, 16'd0);
    repeat (5) @(posedge clk);
    #1;
    chk(1, "pre_reset_out_valid", int'(out_valid_o[1]), 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk(1, "post_reset_outputs", n_out[1], 18);

    // three back-to-back 8x5 frames, random taps, 50% sink
    ready_mode[1] = 2;
    base_out = n_out[1];
    base_fd  = n_fd[1];
    @(posedge clk);
    #1;
    feed(1, 120, M_RAND, 16'd0);
    wait_drain(1);
    chk(1, "rand_outputs", n_out[1] - base_out, 3 * 6 * 3);
    chk(1, "rand_frame_done", n_fd[1] - base_fd, 3);
    chk(1, "rand_busy_idle", int'(busy_o[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
